// File: rtl/reg_file_dump_if.sv
// Beat stream carrying one register value with its index and a last-of-range flag.
// Valid/ready handshake: a beat moves when out_valid and out_ready are both high at a rising edge.
interface reg_file_dump_if #(
  parameter int XLEN = 32,
  parameter int IW   = 5
);
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_data;
  logic [IW-1:0]   out_idx;
  logic            out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_idx,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_idx,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/reg_file_dump.sv
// Walks a register range through one register-file read port and streams each value as a beat.
// 2 cycles per beat (READ then SEND); stalls in SEND with all outputs held while out_ready is low.
module reg_file_dump #(
  parameter  int NUM_REGS = 32,
  parameter  int XLEN     = 32,
  localparam int IW       = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [IW-1:0]   first_reg_i,
  input  logic [IW-1:0]   last_reg_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [IW-1:0]   rd_reg_o,
  input  logic [XLEN-1:0] rd_data_i,
  reg_file_dump_if.master beat_if
);

  typedef enum logic [1:0] {IDLE, READ, SEND} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rd_reg_q, rd_reg_d;   // doubles as the walk index
  logic [IW-1:0]   end_q, end_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [IW-1:0]   oidx_q, oidx_d;
  logic            last_q, last_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rd_reg_q <= '0;
      end_q    <= '0;
      data_q   <= '0;
      oidx_q   <= '0;
      last_q   <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_reg_q <= rd_reg_d;
      end_q    <= end_d;
      data_q   <= data_d;
      oidx_q   <= oidx_d;
      last_q   <= last_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_reg_d = rd_reg_q;
    end_d    = end_q;
    data_d   = data_q;
    oidx_d   = oidx_q;
    last_d   = last_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (first_reg_i <= last_reg_i) begin
            rd_reg_d = first_reg_i;
            end_d    = last_reg_i;
            state_d  = READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        // rd_data reflects the pre-edge contents, so a same-cycle write is not captured.
        data_d  = rd_data_i;
        oidx_d  = rd_reg_q;
        last_d  = (rd_reg_q == end_q);
        valid_d = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (beat_if.out_ready) begin
          valid_d = 1'b0;
          if (last_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            rd_reg_d = rd_reg_q + 1'b1;
            state_d  = READ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o            = (state_q != IDLE);
  assign done_o            = done_q;
  assign rd_reg_o          = rd_reg_q;
  assign beat_if.out_valid = valid_q;
  assign beat_if.out_data  = data_q;
  assign beat_if.out_idx   = oidx_q;
  assign beat_if.out_last  = last_q;

endmodule

// File: doc/reg_file_dump.md
# reg_file_dump

Debug read-out engine for the RISC-V core's 32 x 32-bit register file. On a start pulse it walks a caller-chosen register range through one register-file read port and streams each value out over a valid/ready handshake, tagged with its register index and a last flag. It sits beside the register file and shares a read port with the debug path, so register contents can be dumped without halting writes.

## Interface
- NUM_REGS, 32, register file depth; index width is log2(NUM_REGS) = 5
- XLEN, 32, data width
- clk  input  1  rising-edge clock shared with the register file
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a dump; ignored while busy=1
- first_reg  input  5  first index to dump; sampled only on an accepted start
- last_reg  input  5  last index to dump, inclusive; sampled only on an accepted start
- busy  output  1  high from the cycle after an accepted start until the dump completes
- done  output  1  one-cycle pulse when a dump completes, including an empty dump
- rd_reg  output  5  read address to the register file read port
- rd_data  input  32  combinational read data returned by the register file for rd_reg
- out_valid  output  1  a beat is presented
- out_ready  input  1  consumer accepts the beat when out_valid and out_ready are both high at a rising edge
- out_data  output  32  register value
- out_idx  output  5  index of the register in out_data
- out_last  output  1  beat carries last_reg

## Operation
- FSM states: IDLE, READ, SEND.
- IDLE: busy=0. On start=1:
  - If first_reg <= last_reg: latch idx=first_reg and end=last_reg, then go to READ.
  - If first_reg > last_reg: pulse done on the next cycle, emit no beats, and stay in IDLE.
- READ (one cycle): rd_reg=idx. At the closing edge:
  - capture rd_data into out_data;
  - set out_idx=idx and out_last=(idx==end);
  - go to SEND.
- SEND: out_valid=1. out_data, out_idx and out_last hold steady until the beat is accepted.
  - On accept with out_last=0: idx=idx+1, go to READ.
  - On accept with out_last=1: go to IDLE and pulse done in the following cycle.
- rd_reg holds its last value outside READ and resets to 0. The register file ignores rd_reg while it is unused.
- Coherence: each value is the register file contents at the READ cycle edge. A write to the same register in that cycle is not visible, because the register file reads the old value combinationally. Writes after capture are not reflected in the beat already held.
- x0 reads return whatever the register file returns, which must be 0. The block applies no special case for x0.
- idx never wraps. A dump of 0..31 ends at 31 with out_last=1, and idx does not increment past end.
- start during busy=1 is ignored and its range is not latched.

## Timing
- Reset values: busy=0, done=0, out_valid=0, out_data=0, out_idx=0, out_last=0, rd_reg=0, FSM=IDLE.
- Asserting rst_n mid-dump aborts immediately. Any pending beat is dropped and no done pulse is produced.
- Start accepted at edge T: READ occupies cycle T..T+1, and the first out_valid is high after edge T+1.
- Each beat costs 2 cycles when out_ready is held at 1. A full 32-register dump is therefore 64 cycles, with done high in the cycle after the final accept.
- Backpressure: with out_ready=0 the block stalls indefinitely in SEND and all outputs stay stable.
- Output handshake signals are registered. out_valid does not depend combinationally on out_ready.
- done and the IDLE return:
  - done is a single-cycle pulse.
  - busy falls in the same cycle done rises.
  - A start in the done cycle is accepted.

## Test plan
- Reset then idle: hold rst_n=0 with random inputs. Require all outputs 0. Release reset with no start; out_valid stays 0 for 20 cycles.
- Full dump, no backpressure:
  - Preload x_i = 0xA5000000 | i for i = 1..31.
  - Start with first_reg=0, last_reg=31 and out_ready=1.
  - Require 32 beats with idx 0..31, data 0 then 0xA5000001..0xA500001F, out_last only on idx 31, and done 65 cycles after start.
- Backpressure:
  - Dump 5..7 with out_ready toggled randomly.
  - Require out_data, out_idx and out_last stable while valid and not ready.
  - Require exactly 3 beats (5, 6, 7) in order, then one done pulse.
- Single register and empty range:
  - first_reg=last_reg=9 gives one beat, idx 9, out_last=1, then done.
  - first_reg=10, last_reg=3 gives done one cycle after start and no beats.
- Write collision:
  - Dump 4..4 while writing x4=0xDEADBEEF in the READ cycle, with old x4=0x11111111.
  - Require beat data 0x11111111.
  - A second dump returns 0xDEADBEEF.
- Ignored start and mid-op reset:
  - A start with range 0..0 during a 1..3 dump is ignored, so only beats 1..3 appear.
  - In a separate run, assert rst_n=0 during SEND. Require out_valid=0 immediately, busy=0, and no done pulse.
